shift_chain_ctrl: RTL and testbench

- Sequences one 32-bit serial shift-register chain: accepts a parallel word over a valid/ready handshake, then clears the chain.
- Shifts the word in MSB-first, flushes it through the chain's fixed latency, and deserialises the bits returning on the chain output into a parallel word.
- Sits between a parallel producer/consumer (FSM or bus wrapper) and the serial chain, driving the chain's reset, enable and shift_in pins.

---
 rtl/shift_chain_pkg.sv | 11 +
 rtl/shift_chain_div.sv | 22 ++
 rtl/shift_chain_ctrl.sv | 89 ++++++++
 tb/tb_shift_chain_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/shift_chain_pkg.sv
// shift_chain_pkg: shared state type, default sizing and counter-width helper for the shift chain controller
package shift_chain_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_e;
  localparam int WIDTH_DEF = 32;
  localparam int CHAIN_LAT_DEF = 33;
  localparam int CLK_DIV_DEF = 1;
  // Bit counter must hold WIDTH+CHAIN_LAT itself, since the last divider period completes at that count
  function automatic int cnt_w(input int width, input int lat);
    return $clog2(width + lat + 1);
  endfunction
endpackage

// File: rtl/shift_chain_div.sv
// shift_chain_div: CLK_DIV tick generator; tick marks divider phase 0, wrap marks the last phase
module shift_chain_div
  import shift_chain_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clr_i,
  output logic tick_o,
  output logic wrap_o
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  assign tick_o = div_q == '0;
  assign wrap_o = div_q == DW'(CLK_DIV - 1);
  assign div_d = (clr_i || wrap_o) ? '0 : div_q + 1'b1;
  // Free-running phase counter, held at zero while cleared
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) div_q <= '0;
    else div_q <= div_d;
endmodule

// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: serialises a parallel word into a shift chain and deserialises the returning bits
module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHAIN_LAT = CHAIN_LAT_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             abort_i,
  output logic             chain_clr_o,
  output logic             shift_en_o,
  output logic             shift_bit_o,
  input  logic             chain_out_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o,
  output logic             aborted_o
);
  localparam int TOT = WIDTH + CHAIN_LAT;
  localparam int CW = cnt_w(WIDTH, CHAIN_LAT);
  state_e state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_q, rx_q, rx_d, rxd_q;
  logic ab_q, tick, wrap, done;
  shift_chain_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .clr_i  (state_q != SHIFT),
    .tick_o (tick),
    .wrap_o (wrap)
  );
  assign cnt_d = cnt_q + CW'(tick);
  assign rx_d = {rx_q[WIDTH-2:0], chain_out_i};
  // The transfer ends only once the final enable's divider period has fully elapsed
  assign done = wrap && cnt_d == CW'(TOT);
  assign start_ready_o = state_q == IDLE;
  assign chain_clr_o = state_q == CLEAR;
  assign shift_en_o = state_q == SHIFT && tick;
  assign shift_bit_o = state_q == SHIFT && cnt_q < CW'(WIDTH) && tx_q[WIDTH-1];
  assign rx_valid_o = state_q == DONE;
  assign busy_o = state_q != IDLE;
  assign aborted_o = ab_q;
  assign rx_data_o = rxd_q;
  // Transfer sequencing, serialiser and deserialiser; rx_data is loaded on entry to DONE so it is valid alongside rx_valid
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      rxd_q <= '0;
      ab_q <= 1'b0;
    end else begin
      ab_q <= 1'b0;
      case (state_q)
        IDLE:
          if (start_valid_i) begin
            tx_q <= tx_data_i;
            state_q <= CLEAR;
          end
        CLEAR: begin
          cnt_q <= '0;
          state_q <= abort_i ? IDLE : SHIFT;
          ab_q <= abort_i;
        end
        SHIFT:
          if (abort_i) begin
            state_q <= IDLE;
            ab_q <= 1'b1;
          end else begin
            if (tick) begin
              tx_q <= tx_q << 1;
              cnt_q <= cnt_d;
              if (cnt_q >= CW'(CHAIN_LAT)) rx_q <= rx_d;
            end
            if (done) begin
              state_q <= DONE;
              rxd_q <= tick ? rx_d : rx_q;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb_shift_chain_ctrl: scoreboard bench driving a CLK_DIV=1 and a CLK_DIV=3 controller through loopback chain models
module tb_shift_chain_ctrl;
  typedef struct {
    int inst;
    logic [31:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] sv, sr, ab, clr, en, sb, co, rxv, busy, abd;
  logic [1:0][31:0] tx, rx;
  logic [1:0][32:0] ch;
  exp_t q[$];
  int vec = 0, errs = 0, cyc = 0;
  int acc[2], nen[2], last[2];
  logic [31:0] a1;
  int n;
  logic ok;
  always #5 clk = ~clk;
  shift_chain_ctrl u0 (
    .clock_i(clk), .reset_i(rst), .start_valid_i(sv[0]), .start_ready_o(sr[0]),
    .tx_data_i(tx[0]), .abort_i(ab[0]), .chain_clr_o(clr[0]), .shift_en_o(en[0]),
    .shift_bit_o(sb[0]), .chain_out_i(co[0]), .rx_data_o(rx[0]), .rx_valid_o(rxv[0]),
    .busy_o(busy[0]), .aborted_o(abd[0])
  );
  shift_chain_ctrl #(.CLK_DIV(3)) u1 (
    .clock_i(clk), .reset_i(rst), .start_valid_i(sv[1]), .start_ready_o(sr[1]),
    .tx_data_i(tx[1]), .abort_i(ab[1]), .chain_clr_o(clr[1]), .shift_en_o(en[1]),
    .shift_bit_o(sb[1]), .chain_out_i(co[1]), .rx_data_o(rx[1]), .rx_valid_o(rxv[1]),
    .busy_o(busy[1]), .aborted_o(abd[1])
  );
  // Chain models: a bit shifted in appears on the output after 33 enables
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (clr[i]) ch[i] <= '0;
      else if (en[i]) ch[i] <= {ch[i][31:0], sb[i]};
  assign co = {ch[1][32], ch[0][32]};
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // Cycle numbering: the handshake cycle is cycle 0
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++)
      if (sv[i] && sr[i]) begin
        acc[i] = cyc - 1;
        nen[i] = 0;
      end
  end
  // Monitor: timing of clear/enable pulses and scoreboard pop on rx_valid
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 2; i++) begin
        if (clr[i]) chk($sformatf("clr_cycle%0d", i), 64'(cyc - acc[i]), 64'd1);
        if (en[i]) begin
          if (nen[i] == 0) chk($sformatf("first_en%0d", i), 64'(cyc - acc[i]), 64'd2);
          else chk($sformatf("en_gap%0d", i), 64'(cyc - last[i]), 64'(i ? 3 : 1));
          last[i] = cyc;
          nen[i]++;
        end
        if (rxv[i]) begin
          if (q.size() == 0 || q[0].inst != i) chk($sformatf("unexpected_rx_valid%0d", i), 64'd1, 64'd0);
          else begin
            chk($sformatf("rx_data%0d", i), 64'(rx[i]), 64'(q[0].d));
            chk($sformatf("rx_latency%0d", i), 64'(cyc - acc[i]), 64'(2 + 65 * (i ? 3 : 1)));
            chk($sformatf("en_count%0d", i), 64'(nen[i]), 64'd65);
            void'(q.pop_front());
          end
        end
      end
  task automatic rcheck(input int i);
    chk($sformatf("rst_ready%0d", i), 64'(sr[i]), 64'd1);
    chk($sformatf("rst_clr%0d", i), 64'(clr[i]), 64'd0);
    chk($sformatf("rst_en%0d", i), 64'(en[i]), 64'd0);
    chk($sformatf("rst_bit%0d", i), 64'(sb[i]), 64'd0);
    chk($sformatf("rst_rxv%0d", i), 64'(rxv[i]), 64'd0);
    chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
    chk($sformatf("rst_aborted%0d", i), 64'(abd[i]), 64'd0);
    chk($sformatf("rst_rx_data%0d", i), 64'(rx[i]), 64'd0);
  endtask
  task automatic acc_wait(input int i);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(posedge clk);
      ok = sv[i] && sr[i];
    end
    #1;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask
  task automatic send(input int i, input logic [31:0] d, input bit push);
    sv[i] = 1'b1;
    tx[i] = d;
    acc_wait(i);
    if (push) q.push_back('{i, d});
    sv[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    for (int k = 0; k < 2000 && (busy[i] || q.size() != 0); k++) @(negedge clk);
    chk($sformatf("idle_timeout%0d", i), 64'(busy[i] || q.size() != 0), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    sv = '0;
    ab = '0;
    tx = '0;
    #12;
    rcheck(0);
    rcheck(1);
    @(negedge clk) rst = 1'b0;
    send(0, 32'hA5A50F0F, 1);
    wait_idle(0);
    send(0, 32'h11111111, 0);
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      if (en[0]) n++;
    end
    @(posedge clk) #1 ab[0] = 1'b1;
    @(posedge clk) #1 ab[0] = 1'b0;
    @(negedge clk);
    chk("abort_pulse", 64'(abd[0]), 64'd1);
    chk("abort_ready", 64'(sr[0]), 64'd1);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_en", 64'(en[0]), 64'd0);
    @(negedge clk);
    chk("abort_one_cycle", 64'(abd[0]), 64'd0);
    repeat (100) @(negedge clk);
    chk("abort_rx_hold", 64'(rx[0]), 64'hA5A50F0F);
    sv[0] = 1'b1;
    tx[0] = 32'hFFFFFFFF;
    acc_wait(0);
    q.push_back('{0, 32'hFFFFFFFF});
    a1 = 32'(acc[0]);
    tx[0] = 32'h00000000;
    acc_wait(0);
    q.push_back('{0, 32'h00000000});
    sv[0] = 1'b0;
    chk("b2b_accept", 64'(acc[0] - int'(a1)), 64'd68);
    wait_idle(0);
    send(0, 32'h0F0F0F0F, 1);
    repeat (20) @(posedge clk);
    #1 sv[0] = 1'b1;
    tx[0] = 32'hFFFF0000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ready_busy", 64'(sr[0]), 64'd0);
    end
    sv[0] = 1'b0;
    for (int k = 0; k < 200 && !rxv[0]; k++) @(negedge clk);
    ab[0] = 1'b1;
    @(negedge clk);
    chk("abort_done_ignored", 64'(abd[0]), 64'd0);
    chk("done_to_idle", 64'(sr[0]), 64'd1);
    @(negedge clk);
    chk("abort_idle_ignored", 64'(abd[0]), 64'd0);
    chk("abort_idle_busy", 64'(busy[0]), 64'd0);
    ab[0] = 1'b0;
    wait_idle(0);
    send(0, 32'hDEADBEEF, 1);
    repeat (30) @(posedge clk);
    #3 rst = 1'b1;
    #1 q.delete();
    rcheck(0);
    rcheck(1);
    @(negedge clk) rst = 1'b0;
    send(0, 32'h12345678, 1);
    wait_idle(0);
    send(1, 32'h80000001, 1);
    wait_idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
